uart_cfg_sequencer: RTL

Synthesizable AXI4 master that configures and polls the UART AXI slave on behalf of on-chip logic. Turns single-word commands (set baud divisor, set data bits, set enable/IRQ bits, read config, wait for FIFO status) into single-beat AXI read-modify-write or polling sequences on the UART register map. Sits between a host/control FSM and the UART slave's AXI port; owns all five AXI channels.

---
 rtl/uart_cfg_sequencer_pkg.sv | 69 ++++++
 rtl/uart_cfg_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_sequencer_pkg.sv
// Shared definitions for the UART configuration sequencer: register map,
// config-word field positions, command encodings, AXI encodings and FSM states.
package uart_cfg_sequencer_pkg;

  localparam logic [31:0] FIFO_TX    = 32'h0000_0000;
  localparam logic [31:0] FIFO_RX    = 32'h0000_0004;
  localparam logic [31:0] COM_CONFIG = 32'h0000_0008;
  localparam logic [31:0] IRQ        = 32'h0000_000C;

  localparam int CFG_BAUD_LSB   = 0;
  localparam int CFG_BAUD_MSB   = 15;
  localparam int CFG_NBITS_LSB  = 16;
  localparam int CFG_NBITS_MSB  = 19;
  localparam int CFG_RX_EN      = 20;
  localparam int CFG_TX_EN      = 21;
  localparam int CFG_RX_IRQ_EN  = 22;
  localparam int CFG_TX_IRQ_EN  = 23;
  localparam int FIFO_EMPTY_BIT = 1;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    OP_READ_CFG          = 3'd0,
    OP_SET_BAUD          = 3'd1,
    OP_SET_NBITS         = 3'd2,
    OP_SET_FLAGS         = 3'd3,
    OP_WAIT_TX_EMPTY     = 3'd4,
    OP_WAIT_RX_NOT_EMPTY = 3'd5
  } cmd_op_e;

  localparam logic [2:0] OP_LAST_LEGAL = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RADDR,
    ST_RDATA,
    ST_MODIFY,
    ST_WRITE,
    ST_WRESP,
    ST_GAP,
    ST_DONE
  } state_e;

  function automatic logic [31:0] op_read_addr(input cmd_op_e op);
    case (op)
      OP_WAIT_TX_EMPTY:     return FIFO_TX;
      OP_WAIT_RX_NOT_EMPTY: return FIFO_RX;
      default:              return COM_CONFIG;
    endcase
  endfunction

  // Flags use arg[3:0] as a per-bit write mask and arg[7:4] as the new values.
  function automatic logic [31:0] cfg_modify(input logic [31:0] old_cfg,
                                             input cmd_op_e     op,
                                             input logic [15:0] arg);
    logic [31:0] res;
    res = old_cfg;
    case (op)
      OP_SET_BAUD:  res[CFG_BAUD_MSB:CFG_BAUD_LSB] = arg;
      OP_SET_NBITS: res[CFG_NBITS_MSB:CFG_NBITS_LSB] = arg[3:0];
      OP_SET_FLAGS: res[CFG_TX_IRQ_EN:CFG_RX_EN] =
                      (old_cfg[CFG_TX_IRQ_EN:CFG_RX_EN] & ~arg[3:0]) | (arg[7:4] & arg[3:0]);
      default: ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uart_cfg_sequencer.sv
// AXI4 master that turns single-word commands into read-modify-write or
// status-polling sequences on the UART register map.
module uart_cfg_sequencer
  import uart_cfg_sequencer_pkg::*;
#(
  parameter int POLL_GAP = 16,
  parameter int POLL_MAX = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_op_i,
  input  logic [15:0] cmd_arg_i,
  output logic        done_o,
  output logic        done_err_o,
  output logic [31:0] rd_data_o,
  output logic [31:0] aw_add_o,
  output logic [7:0]  aw_len_o,
  output logic [1:0]  aw_burst_o,
  output logic        aw_valid_o,
  input  logic        aw_ready_i,
  output logic [31:0] w_data_o,
  output logic [3:0]  w_strb_o,
  output logic        w_last_o,
  output logic        w_valid_o,
  input  logic        w_ready_i,
  input  logic [1:0]  b_response_i,
  input  logic        b_valid_i,
  output logic        b_ready_o,
  output logic [31:0] ar_add_o,
  output logic [7:0]  ar_len_o,
  output logic [1:0]  ar_burst_o,
  output logic        ar_valid_o,
  input  logic        ar_ready_i,
  input  logic [31:0] r_data_i,
  input  logic [1:0]  r_resp_i,
  input  logic        r_last_i,
  input  logic        r_valid_i,
  output logic        r_ready_o
);

  localparam int PCW = $clog2(POLL_MAX + 1);
  localparam int GCW = $clog2(POLL_GAP + 1);

  state_e         state_q;
  cmd_op_e        op_q;
  logic [15:0]    arg_q;
  logic           err_q;
  logic [PCW-1:0] poll_cnt_q;
  logic [PCW-1:0] poll_cnt_d;
  logic [GCW-1:0] gap_cnt_q;
  logic           cmd_ready_q;
  logic           done_q;
  logic           done_err_q;
  logic [31:0]    rd_data_q;
  logic [31:0]    aw_add_q;
  logic           aw_valid_q;
  logic [31:0]    w_data_q;
  logic           w_valid_q;
  logic           b_ready_q;
  logic [31:0]    ar_add_q;
  logic           ar_valid_q;
  logic           r_ready_q;
  logic           poll_met;
  logic           aw_done;
  logic           w_done;
  logic           unused_r_last;

  // Single-beat reads: the last flag carries no information.
  assign unused_r_last = r_last_i;

  assign poll_cnt_d = poll_cnt_q + PCW'(1);
  assign poll_met   = (op_q == OP_WAIT_TX_EMPTY) ? r_data_i[FIFO_EMPTY_BIT]
                                                 : !r_data_i[FIFO_EMPTY_BIT];
  assign aw_done    = !aw_valid_q || aw_ready_i;
  assign w_done     = !w_valid_q || w_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ_CFG;
      arg_q       <= '0;
      err_q       <= 1'b0;
      poll_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
      rd_data_q   <= '0;
      aw_add_q    <= '0;
      aw_valid_q  <= 1'b0;
      w_data_q    <= '0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_add_q    <= '0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid_i && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            arg_q       <= cmd_arg_i;
            err_q       <= 1'b0;
            poll_cnt_q  <= '0;
            if (cmd_op_i > OP_LAST_LEGAL) begin
              err_q      <= 1'b1;
              done_q     <= 1'b1;
              done_err_q <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              op_q       <= cmd_op_e'(cmd_op_i);
              ar_add_q   <= op_read_addr(cmd_op_e'(cmd_op_i));
              ar_valid_q <= 1'b1;
              state_q    <= ST_RADDR;
            end
          end
        end
        ST_RADDR: begin
          if (ar_ready_i) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (r_valid_i) begin
            r_ready_q <= 1'b0;
            rd_data_q <= r_data_i;
            if (r_resp_i != AXI_RESP_OKAY) begin
              err_q      <= 1'b1;
              done_q     <= 1'b1;
              done_err_q <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              case (op_q)
                OP_READ_CFG: begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
                end
                OP_SET_BAUD, OP_SET_NBITS, OP_SET_FLAGS: state_q <= ST_MODIFY;
                default: begin
                  poll_cnt_q <= poll_cnt_d;
                  if (poll_met) begin
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                  end else if (poll_cnt_d >= PCW'(POLL_MAX)) begin
                    err_q      <= 1'b1;
                    done_q     <= 1'b1;
                    done_err_q <= 1'b1;
                    state_q    <= ST_DONE;
                  end else begin
                    gap_cnt_q <= '0;
                    state_q   <= ST_GAP;
                  end
                end
              endcase
            end
          end
        end
        ST_MODIFY: begin
          w_data_q   <= cfg_modify(rd_data_q, op_q, arg_q);
          aw_add_q   <= COM_CONFIG;
          aw_valid_q <= 1'b1;
          w_valid_q  <= 1'b1;
          state_q    <= ST_WRITE;
        end
        ST_WRITE: begin
          // Address and data channels complete independently, in either order.
          if (aw_ready_i) aw_valid_q <= 1'b0;
          if (w_ready_i)  w_valid_q  <= 1'b0;
          if (aw_done && w_done) begin
            b_ready_q <= 1'b1;
            state_q   <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (b_valid_i) begin
            b_ready_q  <= 1'b0;
            done_q     <= 1'b1;
            done_err_q <= err_q || (b_response_i != AXI_RESP_OKAY);
            state_q    <= ST_DONE;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GCW'(POLL_GAP - 1)) begin
            ar_valid_q <= 1'b1;
            state_q    <= ST_RADDR;
          end else begin
            gap_cnt_q <= gap_cnt_q + GCW'(1);
          end
        end
        ST_DONE: begin
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign done_o      = done_q;
  assign done_err_o  = done_err_q;
  assign rd_data_o   = rd_data_q;
  assign aw_add_o    = aw_add_q;
  assign aw_len_o    = 8'd0;
  assign aw_burst_o  = AXI_BURST_INCR;
  assign aw_valid_o  = aw_valid_q;
  assign w_data_o    = w_data_q;
  assign w_strb_o    = 4'hF;
  assign w_last_o    = w_valid_q;
  assign w_valid_o   = w_valid_q;
  assign b_ready_o   = b_ready_q;
  assign ar_add_o    = ar_add_q;
  assign ar_len_o    = 8'd0;
  assign ar_burst_o  = AXI_BURST_INCR;
  assign ar_valid_o  = ar_valid_q;
  assign r_ready_o   = r_ready_q;

endmodule
